// File: rtl/riscv_xc_pkg.sv
// Shared types and constants for the XCrypto xc.init sequencer.
package riscv_xc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      VERIFY = 2'd2,
      DONE   = 2'd3
   } xc_init_state_e;

   localparam int         NUM_XC_WORDS = 16;
   localparam logic [6:0] XC_BASE      = 7'h40;

   function automatic int xc_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int XC_IDX_W = xc_idx_w(NUM_XC_WORDS);

endpackage

// File: rtl/riscv_xc_wport_mux.sv
// Register-file write port B arbiter: writeback always wins, the sequencer gets idle cycles.
module riscv_xc_wport_mux #(
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  seq_active_i,
   input  logic [ADDR_WIDTH-1:0] seq_waddr_i,
   input  logic [ADDR_WIDTH-1:0] wb_waddr_i,
   input  logic [DATA_WIDTH-1:0] wb_wdata_i,
   input  logic                  wb_we_i,
   output logic [ADDR_WIDTH-1:0] waddr_o,
   output logic [DATA_WIDTH-1:0] wdata_o,
   output logic                  we_o,
   output logic                  grant_seq_o
);

   assign grant_seq_o = seq_active_i & ~wb_we_i;
   assign we_o        = wb_we_i | grant_seq_o;
   assign waddr_o     = grant_seq_o ? seq_waddr_i : wb_waddr_i;
   assign wdata_o     = grant_seq_o ? '0 : wb_wdata_i;

endmodule

// File: rtl/riscv_xc_init_seq.sv
// xc.init sequencer: stalls the pipeline and zeroes the XC register bank through write port B.
// Define RISCV_XC_INIT_VERIFY_EN to add a read-back verify pass on read port C.
module riscv_xc_init_seq
   import riscv_xc_pkg::*;
#(
   parameter int ADDR_WIDTH   = 7,
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_XC_WORDS = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init_req_i,
   output logic                  init_ack_o,
   output logic                  init_busy_o,
   output logic                  stall_o,
   input  logic [ADDR_WIDTH-1:0] wb_waddr_i,
   input  logic [DATA_WIDTH-1:0] wb_wdata_i,
   input  logic                  wb_we_i,
   output logic [ADDR_WIDTH-1:0] waddr_o,
   output logic [DATA_WIDTH-1:0] wdata_o,
   output logic                  we_o,
   output logic [ADDR_WIDTH-1:0] raddr_o,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   output logic                  init_err_o,
   output xc_init_state_e        dbg_state_o
);

   localparam int                    IDX_W    = xc_idx_w(NUM_XC_WORDS);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_XC_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0] SEQ_BASE = {1'b1, {(ADDR_WIDTH-1){1'b0}}};
`ifdef RISCV_XC_INIT_VERIFY_EN
   localparam xc_init_state_e        CLEAR_NEXT = VERIFY;
`else
   localparam xc_init_state_e        CLEAR_NEXT = DONE;
`endif

   xc_init_state_e          state_q;
   logic [IDX_W-1:0]        idx_q;
   logic [ADDR_WIDTH-1:0]   seq_addr;
   logic                    grant_seq;
   logic                    xc_hit;

   assign seq_addr = SEQ_BASE + ADDR_WIDTH'(idx_q);

   // A writeback landing in the XC bank mid-sequence invalidates everything cleared so far.
   assign xc_hit = wb_we_i & wb_waddr_i[ADDR_WIDTH-1] & ((state_q == CLEAR) | (state_q == VERIFY));

   riscv_xc_wport_mux #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_wport_mux (
      .seq_active_i (state_q == CLEAR),
      .seq_waddr_i  (seq_addr),
      .wb_waddr_i   (wb_waddr_i),
      .wb_wdata_i   (wb_wdata_i),
      .wb_we_i      (wb_we_i),
      .waddr_o      (waddr_o),
      .wdata_o      (wdata_o),
      .we_o         (we_o),
      .grant_seq_o  (grant_seq)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (init_req_i) begin
                  state_q <= CLEAR;
                  idx_q   <= '0;
               end
            end
            CLEAR: begin
               if (xc_hit) begin
                  idx_q <= '0;
               end else if (grant_seq) begin
                  if (idx_q == IDX_LAST) begin
                     idx_q   <= '0;
                     state_q <= CLEAR_NEXT;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            VERIFY: begin
               if (xc_hit) begin
                  idx_q   <= '0;
                  state_q <= CLEAR;
               end else if (idx_q == IDX_LAST) begin
                  idx_q   <= '0;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef RISCV_XC_INIT_VERIFY_EN
   logic err_q;

   // Sticky until the next accepted request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if ((state_q == IDLE) && init_req_i) begin
         err_q <= 1'b0;
      end else if ((state_q == VERIFY) && (rdata_i != '0)) begin
         err_q <= 1'b1;
      end
   end

   assign raddr_o    = (state_q == VERIFY) ? seq_addr : '0;
   assign init_err_o = err_q;
`else
   logic unused_rdata;
   assign unused_rdata = ^rdata_i;
   assign raddr_o      = '0;
   assign init_err_o   = 1'b0;
`endif

   assign init_ack_o  = (state_q == DONE);
   assign init_busy_o = (state_q != IDLE);
   assign stall_o     = (state_q != IDLE) | init_req_i;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_riscv_xc_init_seq.sv
// Bench for riscv_xc_init_seq: directed sequences plus random traffic against a progress-count model.
module tb_riscv_xc_init_seq;

   localparam int AW = 7;
   localparam int DW = 32;
   localparam int NW = 16;
`ifdef RISCV_XC_INIT_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif
   localparam int          TOTAL = VERIFY ? 2 * NW : NW;
   localparam logic [AW-1:0] XCB = 7'h40;

   logic          clk = 1'b0;
   logic          rst;
   logic          init_req, init_ack, init_busy, stall;
   logic [AW-1:0] wb_waddr, waddr, raddr;
   logic [DW-1:0] wb_wdata, wdata, rdata;
   logic          wb_we, we, init_err;
   logic [1:0]    dbg_state;
   logic          bad_en;
   logic [DW-1:0] rdata_noise;

   // Register file read model: one poisoned word at 0x47 when bad_en is set.
   assign rdata = (bad_en && raddr == 7'h47) ? 32'hDEADBEEF : rdata_noise;

   always #5 clk = ~clk;

   riscv_xc_init_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_XC_WORDS(NW)) dut (
      .clk (clk), .rst (rst),
      .init_req_i (init_req), .init_ack_o (init_ack), .init_busy_o (init_busy), .stall_o (stall),
      .wb_waddr_i (wb_waddr), .wb_wdata_i (wb_wdata), .wb_we_i (wb_we),
      .waddr_o (waddr), .wdata_o (wdata), .we_o (we),
      .raddr_o (raddr), .rdata_i (rdata), .init_err_o (init_err),
      .dbg_state_o (dbg_state)
   );

   int n_cmp = 0, n_bad = 0, cyc = 0;
   int req_cyc = 0, ack_cyc = 0, seq_writes = 0, n_acks = 0;

   // Model: a sequence is just a count of completed steps; 0..NW-1 clearing, NW..TOTAL-1 verifying, TOTAL acking.
   bit m_run = 0;
   int m_prog = 0;
   bit m_err = 0;
   bit s_rst, s_req, s_we, s_xc;
   logic [DW-1:0] s_rdata;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_ports();
      logic          e_we;
      logic [AW-1:0] e_waddr, e_raddr;
      logic [DW-1:0] e_wdata;
      bit            e_ack;
      if (rst) begin
         m_run = 0; m_prog = 0; m_err = 0;
      end
      if (m_run && m_prog < NW && !wb_we) begin
         e_we = 1'b1; e_waddr = XCB + AW'(m_prog); e_wdata = '0;
      end else begin
         e_we = wb_we; e_waddr = wb_waddr; e_wdata = wb_wdata;
      end
      e_raddr = (VERIFY && m_run && m_prog >= NW && m_prog < TOTAL) ? XCB + AW'(m_prog - NW) : '0;
      e_ack   = m_run && m_prog == TOTAL;
      check("wport", 64'({we, waddr, wdata}), 64'({e_we, e_waddr, e_wdata}));
      check("raddr", 64'(raddr), 64'(e_raddr));
      check("ctrl", 64'({init_ack, init_busy, stall, init_err}),
            64'({e_ack, m_run, m_run | init_req, m_err}));
      if (init_ack) begin ack_cyc = cyc; n_acks++; end
      if (we && !wb_we) seq_writes++;
      s_rst = rst; s_req = init_req; s_we = wb_we; s_xc = wb_waddr[AW-1]; s_rdata = rdata;
   endtask

   task automatic model_step();
      if (s_rst) begin
         m_run = 0; m_prog = 0; m_err = 0;
      end else if (!m_run) begin
         if (s_req) begin m_run = 1; m_prog = 0; m_err = 0; req_cyc = cyc; end
      end else if (m_prog == TOTAL) begin
         m_run = 0;
      end else begin
         if (m_prog >= NW && s_rdata != '0) m_err = 1;
         if (s_we && s_xc) m_prog = 0;
         else if (m_prog >= NW || !s_we) m_prog++;
      end
   endtask

   task automatic cycle();
      #2 check_ports();
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
   endtask

   task automatic wb_idle();
      wb_we = 1'b0; wb_waddr = AW'($urandom_range(0, 127)); wb_wdata = $urandom;
   endtask

   // Holds the request until ack; optionally injects writeback hits while the model sits at hit_prog.
   task automatic run_seq(input int hit_prog, input bit hit_xc, input int hit_len,
                          output int lat, output int writes);
      int a0 = n_acks;
      int hits = 0;
      lat = -1;
      init_req = 1'b1;
      seq_writes = 0;
      for (int i = 0; i < 200; i++) begin
         wb_idle();
         if (m_run && m_prog == hit_prog && hits < hit_len) begin
            wb_we = 1'b1; wb_waddr = hit_xc ? 7'h43 : 7'h05; hits++;
         end
         cycle();
         if (n_acks != a0) begin lat = ack_cyc - req_cyc; break; end
      end
      writes = seq_writes;
      init_req = 1'b0;
      wb_idle();
   endtask

   initial begin
      int lat, wr, a0, first;
      rst = 1'b1; init_req = 1'b0; bad_en = 1'b0; rdata_noise = '0; wb_idle();
      @(negedge clk);
      cycle();
      check("rst_busy", 64'(init_busy), 64'(0));
      check("rst_raddr", 64'(raddr), 64'(0));
      rst = 1'b0;
      cycle();

      run_seq(-1, 1'b0, 0, lat, wr);
      check("lat_plain", 64'(lat), 64'(TOTAL + 1));
      check("writes_plain", 64'(wr), 64'(NW));
      cycle();

      run_seq(6, 1'b0, 3, lat, wr);
      check("lat_contend", 64'(lat), 64'(TOTAL + 4));
      check("writes_contend", 64'(wr), 64'(NW));
      cycle();

      run_seq(8, 1'b1, 1, lat, wr);
      check("lat_restart", 64'(lat), 64'(TOTAL + 10));
      check("writes_restart", 64'(wr), 64'(NW + 8));
      cycle();

      bad_en = 1'b1;
      run_seq(-1, 1'b0, 0, lat, wr);
      check("lat_bad", 64'(lat), 64'(TOTAL + 1));
      bad_en = 1'b0;
      cycle();
      check("err_sticky", 64'(init_err), 64'(VERIFY));
      init_req = 1'b1;
      cycle();
      cycle();
      check("err_clear", 64'(init_err), 64'(0));
      run_seq(-1, 1'b0, 0, lat, wr);
      check("lat_after_err", 64'(lat), 64'(TOTAL + 1));
      cycle();

      init_req = 1'b1; a0 = n_acks;
      for (int i = 0; i < 40 && !(m_run && m_prog == 5); i++) cycle();
      init_req = 1'b0; rst = 1'b1;
      cycle();
      check("rst_mid_busy", 64'(init_busy), 64'(0));
      check("rst_mid_we", 64'(we), 64'(wb_we));
      rst = 1'b0;
      cycle();
      check("rst_noack", 64'(n_acks), 64'(a0));
      run_seq(-1, 1'b0, 0, lat, wr);
      check("lat_post_rst", 64'(lat), 64'(TOTAL + 1));
      check("writes_post_rst", 64'(wr), 64'(NW));
      cycle();

      init_req = 1'b1; a0 = n_acks; first = -1;
      for (int i = 0; i < 120 && n_acks - a0 < 2; i++) begin
         wb_idle();
         cycle();
         if (n_acks - a0 == 1 && first < 0) first = ack_cyc;
      end
      check("b2b_acks", 64'(n_acks - a0), 64'(2));
      check("b2b_gap", 64'(ack_cyc - first), 64'(TOTAL + 2));
      init_req = 1'b0;
      cycle();

      a0 = n_acks;
      for (int i = 0; i < 1500; i++) begin
         if (n_acks != a0) begin init_req = 1'($urandom_range(0, 1)); a0 = n_acks; end
         else if (!init_req) init_req = ($urandom_range(0, 7) == 0);
         wb_we    = ($urandom_range(0, 3) == 0);
         wb_waddr = AW'($urandom_range(0, 63));
         if ($urandom_range(0, 15) == 0) wb_waddr[AW-1] = 1'b1;
         wb_wdata = $urandom;
         rdata_noise = VERIFY ? (($urandom_range(0, 19) == 0) ? $urandom : '0) : $urandom;
         rst = ($urandom_range(0, 299) == 0);
         cycle();
      end
      rst = 1'b0; init_req = 1'b0; rdata_noise = '0; wb_idle();
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
